// File: rtl/dcache_pkg.sv
// Shared types and widths for the D$ port arbiter: FSM state encodings, grant
// identifiers and the latched D$ request payload.
package dcache_pkg;

    localparam int DC_INDEX_W = 19;
    localparam int DC_DATA_W  = 64;
    localparam int DC_MASK_W  = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } arb_state_e;

    // Plain constants mirror arb_state_e for code that carries state as raw bits.
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;

    typedef enum logic {
        LOAD  = 1'b0,
        STORE = 1'b1
    } grant_e;

    typedef struct packed {
        logic                  is_write;
        logic [DC_INDEX_W-1:0] index;
        logic [DC_MASK_W-1:0]  wmask;
        logic [DC_DATA_W-1:0]  wdata;
    } dc_req_t;

    // Loads never carry write payload, so mask and data are forced to zero.
    function automatic dc_req_t make_load_req(input logic [DC_INDEX_W-1:0] index);
        dc_req_t r;
        r.is_write = 1'b0;
        r.index    = index;
        r.wmask    = '0;
        r.wdata    = '0;
        return r;
    endfunction

    function automatic dc_req_t make_store_req(input logic [DC_INDEX_W-1:0] index,
                                               input logic [DC_MASK_W-1:0]  wmask,
                                               input logic [DC_DATA_W-1:0]  wdata);
        dc_req_t r;
        r.is_write = 1'b1;
        r.index    = index;
        r.wmask    = wmask;
        r.wdata    = wdata;
        return r;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter between the load and store channels; the last
// winner loses the next tie. Ready depends only on the other channel's valid.
module rr_arb2 (
    input  logic clock,
    input  logic reset,
    input  logic enable_i,
    input  logic ld_valid_i,
    input  logic st_valid_i,
    output logic ld_ready_o,
    output logic st_ready_o,
    output logic ld_accept_o,
    output logic st_accept_o
);
    import dcache_pkg::*;

    grant_e last_grant_q;
    grant_e last_grant_d;

    assign ld_ready_o  = enable_i & (~st_valid_i | (last_grant_q == STORE));
    assign st_ready_o  = enable_i & (~ld_valid_i | (last_grant_q == LOAD));
    assign ld_accept_o = ld_valid_i & ld_ready_o;
    assign st_accept_o = st_valid_i & st_ready_o;

    always_comb begin
        last_grant_d = last_grant_q;
        if (ld_accept_o) begin
            last_grant_d = LOAD;
        end else if (st_accept_o) begin
            last_grant_d = STORE;
        end
    end

    // Starting from STORE lets the load win the very first tie.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            last_grant_q <= STORE;
        end else begin
            last_grant_q <= last_grant_d;
        end
    end

endmodule

// File: rtl/dcache_port_arbiter.sv
// Shares the single L1 D$ request port between the MEM-stage load and store
// channels, keeping exactly one D$ transaction outstanding at a time.
module dcache_port_arbiter
    import dcache_pkg::*;
#(
    parameter int INDEX_W = DC_INDEX_W,
    parameter int DATA_W  = DC_DATA_W,
    parameter int MASK_W  = DC_MASK_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flush,
    input  logic               ld_valid,
    input  logic [INDEX_W-1:0] ld_index,
    output logic               ld_ready,
    output logic [DATA_W-1:0]  ld_read_data,
    output logic               ld_done,
    input  logic               st_valid,
    input  logic [INDEX_W-1:0] st_index,
    input  logic [MASK_W-1:0]  st_write_mask,
    input  logic [DATA_W-1:0]  st_write_data,
    output logic               st_ready,
    output logic               st_done,
    output logic               dc_req_valid,
    input  logic               dc_req_ready,
    output logic               dc_req_is_write,
    output logic [INDEX_W-1:0] dc_req_index,
    output logic [MASK_W-1:0]  dc_req_wmask,
    output logic [DATA_W-1:0]  dc_req_wdata,
    input  logic               dc_resp_valid,
    input  logic [DATA_W-1:0]  dc_resp_rdata,
    output logic               busy
);

    logic [1:0]        state_q, state_d;
    dc_req_t           req_q, req_d;
    logic              kill_q, kill_d;
    logic              ld_done_q, ld_done_d;
    logic              st_done_q, st_done_d;
    logic [DATA_W-1:0] ld_data_q, ld_data_d;

    logic arb_enable;
    logic ld_accept;
    logic st_accept;
    logic kill_now;

    // Ready is also held low while reset is asserted so nothing looks accepted.
    assign arb_enable = (state_q == ST_IDLE) & ~flush & ~reset;

    rr_arb2 u_rr_arb2 (
        .clock       (clock),
        .reset       (reset),
        .enable_i    (arb_enable),
        .ld_valid_i  (ld_valid),
        .st_valid_i  (st_valid),
        .ld_ready_o  (ld_ready),
        .st_ready_o  (st_ready),
        .ld_accept_o (ld_accept),
        .st_accept_o (st_accept)
    );

    // A flush landing in the same cycle as the response still kills the load.
    assign kill_now = kill_q | (flush & ~req_q.is_write);

    always_comb begin
        state_d   = state_q;
        req_d     = req_q;
        kill_d    = kill_q;
        ld_done_d = 1'b0;
        st_done_d = 1'b0;
        ld_data_d = ld_data_q;
        case (state_q)
            ST_IDLE: begin
                kill_d = 1'b0;
                if (ld_accept) begin
                    req_d   = make_load_req(ld_index);
                    state_d = ST_REQ;
                end else if (st_accept) begin
                    req_d   = make_store_req(st_index, st_write_mask, st_write_data);
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                kill_d = kill_now;
                if (dc_req_ready) begin
                    state_d = ST_WAIT;
                end
            end
            ST_WAIT: begin
                kill_d = kill_now;
                if (dc_resp_valid) begin
                    state_d = ST_IDLE;
                    kill_d  = 1'b0;
                    if (req_q.is_write) begin
                        st_done_d = 1'b1;
                    end else if (!kill_now) begin
                        ld_done_d = 1'b1;
                        ld_data_d = dc_resp_rdata;
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                kill_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            req_q     <= '0;
            kill_q    <= 1'b0;
            ld_done_q <= 1'b0;
            st_done_q <= 1'b0;
            ld_data_q <= '0;
        end else begin
            state_q   <= state_d;
            req_q     <= req_d;
            kill_q    <= kill_d;
            ld_done_q <= ld_done_d;
            st_done_q <= st_done_d;
            ld_data_q <= ld_data_d;
        end
    end

    // All D$-side outputs come straight from flops: no ready-to-valid path.
    assign dc_req_valid    = (state_q == ST_REQ);
    assign dc_req_is_write = req_q.is_write;
    assign dc_req_index    = req_q.index;
    assign dc_req_wmask    = req_q.wmask;
    assign dc_req_wdata    = req_q.wdata;
    assign ld_done         = ld_done_q;
    assign st_done         = st_done_q;
    assign ld_read_data    = ld_data_q;
    assign busy            = (state_q != ST_IDLE);

    resp_only_in_wait: assert property (
        @(posedge clock) disable iff (reset)
        dc_resp_valid |-> (state_q == ST_WAIT)
    );

    never_both_accept: assert property (
        @(posedge clock) disable iff (reset)
        !(ld_accept && st_accept)
    );

    req_payload_stable: assert property (
        @(posedge clock) disable iff (reset)
        (dc_req_valid && !dc_req_ready) |=> (dc_req_valid && $stable(req_q))
    );

endmodule

// File: tb/tb_dcache_port_arbiter.sv
// Directed bench for dcache_port_arbiter: hand-computed vectors for load, store,
// round-robin, flush/kill and mid-transaction reset behaviour.
module tb_dcache_port_arbiter;

    logic        clock;
    logic        reset;
    logic        flush;
    logic        ld_valid;
    logic [18:0] ld_index;
    logic        ld_ready;
    logic [63:0] ld_read_data;
    logic        ld_done;
    logic        st_valid;
    logic [18:0] st_index;
    logic [63:0] st_write_mask;
    logic [63:0] st_write_data;
    logic        st_ready;
    logic        st_done;
    logic        dc_req_valid;
    logic        dc_req_ready;
    logic        dc_req_is_write;
    logic [18:0] dc_req_index;
    logic [63:0] dc_req_wmask;
    logic [63:0] dc_req_wdata;
    logic        dc_resp_valid;
    logic [63:0] dc_resp_rdata;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;

    dcache_port_arbiter dut (
        .clock           (clock),
        .reset           (reset),
        .flush           (flush),
        .ld_valid        (ld_valid),
        .ld_index        (ld_index),
        .ld_ready        (ld_ready),
        .ld_read_data    (ld_read_data),
        .ld_done         (ld_done),
        .st_valid        (st_valid),
        .st_index        (st_index),
        .st_write_mask   (st_write_mask),
        .st_write_data   (st_write_data),
        .st_ready        (st_ready),
        .st_done         (st_done),
        .dc_req_valid    (dc_req_valid),
        .dc_req_ready    (dc_req_ready),
        .dc_req_is_write (dc_req_is_write),
        .dc_req_index    (dc_req_index),
        .dc_req_wmask    (dc_req_wmask),
        .dc_req_wdata    (dc_req_wdata),
        .dc_resp_valid   (dc_resp_valid),
        .dc_resp_rdata   (dc_resp_rdata),
        .busy            (busy)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    // Leaves time 2 units after the rising edge, well clear of both edges.
    task automatic tick();
        @(posedge clock);
        #2;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    initial begin
        int lat;
        logic pend;

        reset = 1'b1; flush = 1'b0;
        ld_valid = 1'b0; ld_index = '0;
        st_valid = 1'b0; st_index = '0; st_write_mask = '0; st_write_data = '0;
        dc_req_ready = 1'b0; dc_resp_valid = 1'b0; dc_resp_rdata = '0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_dc_req_valid", dc_req_valid, 0);
        check("rst_ld_done", ld_done, 0);
        check("rst_st_done", st_done, 0);
        check("rst_ld_read_data", ld_read_data, 0);
        check("rst_ld_ready", ld_ready, 0);
        tick();
        reset = 1'b0;
        settle();

        // 1: load only
        ld_valid = 1'b1; ld_index = 19'h01234; dc_req_ready = 1'b1;
        settle();
        check("t1_ld_ready", ld_ready, 1);
        check("t1_st_ready", st_ready, 0);
        tick();
        ld_valid = 1'b0;
        settle();
        check("t1_dc_req_valid", dc_req_valid, 1);
        check("t1_dc_req_index", dc_req_index, 64'h1234);
        check("t1_is_write", dc_req_is_write, 0);
        check("t1_wmask", dc_req_wmask, 0);
        check("t1_busy", busy, 1);
        tick();
        dc_resp_valid = 1'b1; dc_resp_rdata = 64'hDEADBEEF_CAFEF00D;
        settle();
        check("t1_no_early_done", ld_done, 0);
        tick();
        dc_resp_valid = 1'b0;
        settle();
        check("t1_ld_done", ld_done, 1);
        check("t1_ld_read_data", ld_read_data, 64'hDEADBEEF_CAFEF00D);
        check("t1_busy_idle", busy, 0);
        tick();
        check("t1_ld_done_pulse", ld_done, 0);
        check("t1_ld_read_data_held", ld_read_data, 64'hDEADBEEF_CAFEF00D);

        // 2: store only, D$ stalls for 3 cycles
        st_valid = 1'b1; st_index = 19'h00042; st_write_mask = 64'hFF; st_write_data = 64'hA5;
        dc_req_ready = 1'b0;
        settle();
        check("t2_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) dc_req_ready = 1'b1;
            settle();
            check($sformatf("t2_valid_c%0d", c), dc_req_valid, 1);
            check($sformatf("t2_is_write_c%0d", c), dc_req_is_write, 1);
            check($sformatf("t2_wmask_c%0d", c), dc_req_wmask, 64'hFF);
            check($sformatf("t2_wdata_c%0d", c), dc_req_wdata, 64'hA5);
            tick();
        end
        dc_req_ready = 1'b0;
        check("t2_valid_dropped", dc_req_valid, 0);
        dc_resp_valid = 1'b1;
        tick();
        dc_resp_valid = 1'b0;
        check("t2_st_done", st_done, 1);
        check("t2_no_ld_done", ld_done, 0);
        tick();
        check("t2_st_done_pulse", st_done, 0);

        // 3: both valid from reset -> L,S,L,S
        do_reset();
        ld_valid = 1'b1; st_valid = 1'b1; dc_req_ready = 1'b1;
        settle();
        for (int i = 0; i < 4; i++) begin
            logic exp_st;
            exp_st = (i % 2 == 1);
            ld_index = 19'(32'h100 + i);
            st_index = 19'(32'h200 + i);
            dc_resp_rdata = 64'h1000 + 64'(i);
            settle();
            check($sformatf("t3_ld_ready_%0d", i), ld_ready, {63'b0, !exp_st});
            check($sformatf("t3_st_ready_%0d", i), st_ready, {63'b0, exp_st});
            tick();
            check($sformatf("t3_is_write_%0d", i), dc_req_is_write, {63'b0, exp_st});
            tick();
            dc_resp_valid = 1'b1;
            tick();
            dc_resp_valid = 1'b0;
            check($sformatf("t3_ld_done_%0d", i), ld_done, {63'b0, !exp_st});
            check($sformatf("t3_st_done_%0d", i), st_done, {63'b0, exp_st});
            if (i == 3) begin
                ld_valid = 1'b0;
                st_valid = 1'b0;
            end
        end
        check("t3_ld_read_data", ld_read_data, 64'h1002);

        // 4: flush one cycle after load accept
        ld_valid = 1'b1; ld_index = 19'h00055; dc_req_ready = 1'b0;
        tick();
        ld_valid = 1'b0; flush = 1'b1;
        settle();
        check("t4_req_valid_flush", dc_req_valid, 1);
        tick();
        flush = 1'b0; dc_req_ready = 1'b1;
        settle();
        check("t4_req_still_valid", dc_req_valid, 1);
        check("t4_req_index", dc_req_index, 64'h55);
        tick();
        dc_req_ready = 1'b0; dc_resp_valid = 1'b1; dc_resp_rdata = 64'h0BAD;
        tick();
        dc_resp_valid = 1'b0;
        check("t4_no_ld_done", ld_done, 0);
        check("t4_ld_read_data_kept", ld_read_data, 64'h1002);
        check("t4_busy", busy, 0);
        st_valid = 1'b1; st_index = 19'h00066; st_write_mask = 64'h3; st_write_data = 64'h77;
        dc_req_ready = 1'b1;
        settle();
        check("t4_st_ready", st_ready, 1);
        tick();
        st_valid = 1'b0;
        check("t4_st_wdata", dc_req_wdata, 64'h77);
        tick();
        dc_resp_valid = 1'b1;
        tick();
        dc_resp_valid = 1'b0;
        check("t4_st_done", st_done, 1);

        // 5: flush during store WAIT, then flush in IDLE
        st_valid = 1'b1; st_write_data = 64'h88;
        tick();
        st_valid = 1'b0;
        tick();
        flush = 1'b1; dc_resp_valid = 1'b1;
        tick();
        dc_resp_valid = 1'b0;
        check("t5_st_done", st_done, 1);
        ld_valid = 1'b1;
        settle();
        check("t5_ld_ready_flush", ld_ready, 0);
        check("t5_st_ready_flush", st_ready, 0);
        tick();
        flush = 1'b0; ld_valid = 1'b0;
        check("t5_no_accept", busy, 0);

        // 6: reset in WAIT, then a fresh minimum-latency load
        ld_valid = 1'b1; ld_index = 19'h00077; dc_req_ready = 1'b1;
        tick();
        ld_valid = 1'b0;
        tick();
        check("t6_busy_wait", busy, 1);
        reset = 1'b1;
        settle();
        check("t6_rst_busy", busy, 0);
        check("t6_rst_req_valid", dc_req_valid, 0);
        check("t6_rst_ld_done", ld_done, 0);
        check("t6_rst_st_done", st_done, 0);
        tick();
        reset = 1'b0;
        settle();
        check("t6_post_rst_ld_done", ld_done, 0);
        ld_valid = 1'b1; ld_index = 19'h00099; dc_resp_rdata = 64'hABCD;
        settle();
        check("t6_ld_ready", ld_ready, 1);
        tick();
        ld_valid = 1'b0;
        lat = -1;
        pend = 1'b0;
        for (int cyc = 1; cyc <= 10; cyc++) begin
            if (ld_done && lat < 0) lat = cyc;
            dc_resp_valid = pend;
            pend = dc_req_valid && dc_req_ready;
            tick();
        end
        dc_resp_valid = 1'b0;
        check("t6_latency", 64'(lat), 64'd3);
        check("t6_ld_read_data", ld_read_data, 64'hABCD);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
